rab_cfg_regfile: RTL
====================

Name: rab_cfg_regfile

Overview:
AXI4-Lite slave that owns the RAB slice configuration register array and drives the packed int_cfg_regs bus consumed by the slice lookup logic. Each slice has 4 registers: min, max, offset and flags. The flags register holds en, ren, wen and master_select. The block accepts host programming writes and readback reads, masks each register to its legal field width, and flags out-of-range accesses with SLVERR.

Parameters:
N_SLICES, 16, number of RAB slices
N_REGS, 4*N_SLICES, number of 64-bit config registers
ADDR_WIDTH_PHYS, 40, width of the offset field (reg 4i+2)
ADDR_WIDTH_VIRT, 32, width of the min/max fields (regs 4i, 4i+1)
AXI_ADDR_WIDTH, 32, AXI-Lite address width

Ports:
s_axi_aclk  in  1  clock, all logic on rising edge
s_axi_aresetn  in  1  reset, synchronous, active-low
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address, byte address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  64  write data
s_axi_wstrb  in  8  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response, 00 OKAY / 10 SLVERR
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  AXI_ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  64  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
int_cfg_regs  out  [N_REGS-1:0][63:0]  packed config registers, direct from flops

Behaviour:
- Reset (s_axi_aresetn=0 at a clock edge):
  - all regs, bvalid, rvalid, bresp, rresp, rdata and the internal aw_full/w_full flags go to 0.
  - awready, wready and arready go to 1 in the first cycle after reset is released.
  - Reset asserted mid-transaction aborts it: no B or R beat is issued, and the pending write is dropped.
- Register index = addr >> 3; addr[2:0] ignored. Index >= N_REGS is out of range.
- Field masks are applied on write; stored bits outside the mask are always 0:
  - r%4 in {0,1}: bits [ADDR_WIDTH_VIRT-1:0]
  - r%4 = 2: bits [ADDR_WIDTH_PHYS-1:0]
  - r%4 = 3: bits [3:0]
- Write channel:
  - AW and W are accepted independently, in either order or in the same cycle.
  - awready = !aw_full && !bvalid. wready = !w_full && !bvalid.
  - A handshake latches the address/data+strb and sets the corresponding full flag.
  - In the cycle both flags are set, the write commits at that edge. Per-byte update: byte b is written where wstrb[b]=1, then the field mask is applied.
  - At commit: bvalid=1 next cycle, flags cleared. bresp=10 for out-of-range (no register changes), else 00.
  - bvalid holds, with bresp stable, until bready=1. The next AW/W is accepted the cycle after the B handshake.
  - Latency: AW and W accepted in cycle N -> commit edge at end of N+1 -> bvalid visible in N+2. int_cfg_regs reflects the new value from N+2.
- Read channel:
  - arready = !rvalid.
  - On AR handshake, rdata is registered from the array (masked value), or 0 with rresp=10 if out of range. rvalid=1 next cycle.
  - rvalid/rdata/rresp hold until rready=1. Maximum throughput is one read per 2 cycles.
- Simultaneous write commit and read of the same register in one cycle: the read returns the old value.
- Read and write channels are fully independent; neither stalls the other.
- wstrb=0: write completes with OKAY and changes nothing.

Test Plan:
- Reset then idle -> all int_cfg_regs = 0, awready=wready=arready=1, bvalid=rvalid=0.
- AW addr 0x08 and W data 0xFFFF_FFFF_FFFF_FFFF, strb 0xFF, same cycle -> bvalid 2 cycles later with bresp=00. int_cfg_regs[1] = 0x0000_0000_FFFF_FFFF. Read of 0x08 returns the same value with rresp=00.
- W first (data 0x1234_5678_9ABC_DEF0, strb 0x0F), AW addr 0x10 three cycles later -> int_cfg_regs[2] = 0x0000_0000_9ABC_DEF0. Repeat with strb 0xF0 -> value 0x0000_0078_9ABC_DEF0 (40-bit mask).
- Write 0xFF to addr 0x18 -> int_cfg_regs[3] = 0xF. Write addr 8*N_REGS (0x200) -> bresp=10, all regs unchanged. Read 0x200 -> rdata=0, rresp=10.
- bready held low 5 cycles after a write -> bvalid and bresp stable, awready=wready=0 throughout. Second write is accepted one cycle after bready=1.
- Reset asserted while AW is latched but W is not yet received -> no bvalid after release, and the register is unchanged after a subsequent W-only beat.

Source files
------------

// File: rtl/rab_cfg_regfile.sv
// RAB slice configuration register array behind an AXI4-Lite slave port.
// Holds min/max/offset/flags per slice, masked to legal widths, and drives them flat to the lookup logic.
module rab_cfg_regfile #(
    parameter int N_SLICES        = 16,
    parameter int N_REGS          = 4 * N_SLICES,
    parameter int ADDR_WIDTH_PHYS = 40,
    parameter int ADDR_WIDTH_VIRT = 32,
    parameter int AXI_ADDR_WIDTH  = 32
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_awaddr,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [63:0]                s_axi_wdata,
    input  logic [7:0]                 s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [63:0]                s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [N_REGS-1:0][63:0]    int_cfg_regs
);

    localparam int               IDX_W       = (N_REGS > 4) ? $clog2(N_REGS) : 2;
    localparam int               WORD_W      = AXI_ADDR_WIDTH - 3;
    localparam logic [WORD_W-1:0] N_REGS_W   = WORD_W'(N_REGS);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    // Legal bits per register kind: 0/1 = virtual min/max, 2 = physical offset, 3 = flags.
    function automatic logic [63:0] field_mask(input logic [1:0] kind);
        logic [63:0] m;
        int          width;
        case (kind)
            2'd2:    width = ADDR_WIDTH_PHYS;
            2'd3:    width = 4;
            default: width = ADDR_WIDTH_VIRT;
        endcase
        for (int i = 0; i < 64; i++) begin
            m[i] = (i < width);
        end
        return m;
    endfunction

    logic                    aw_full_q, aw_full_d;
    logic [WORD_W-1:0]       aw_word_q, aw_word_d;
    logic                    w_full_q, w_full_d;
    logic [63:0]             w_data_q, w_data_d;
    logic [7:0]              w_strb_q, w_strb_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    rvalid_q, rvalid_d;
    logic [63:0]             rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [N_REGS-1:0][63:0] regs_q, regs_d;

    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic              aw_in_range, ar_in_range;
    logic [IDX_W-1:0]  aw_sel, ar_sel;
    logic [WORD_W-1:0] ar_word;
    logic [63:0]       merged;
    logic              unused_addr_lsbs;

    // Every channel transfers exactly on the rising edge where valid && ready are both high;
    // ready never depends on valid, and a raised valid with its payload holds until that edge.
    assign s_axi_awready = !aw_full_q && !bvalid_q;
    assign s_axi_wready  = !w_full_q && !bvalid_q;
    assign s_axi_arready = !rvalid_q;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign b_hs   = bvalid_q && s_axi_bready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign r_hs   = rvalid_q && s_axi_rready;
    assign commit = aw_full_q && w_full_q;

    assign ar_word     = s_axi_araddr[AXI_ADDR_WIDTH-1:3];
    assign aw_in_range = aw_word_q < N_REGS_W;
    assign ar_in_range = ar_word < N_REGS_W;
    assign aw_sel      = aw_word_q[IDX_W-1:0];
    assign ar_sel      = ar_word[IDX_W-1:0];

    // Byte offset within a 64-bit register carries no meaning.
    assign unused_addr_lsbs = ^{s_axi_awaddr[2:0], s_axi_araddr[2:0]};

    always_comb begin
        merged = regs_q[aw_sel];
        for (int b = 0; b < 8; b++) begin
            if (w_strb_q[b]) begin
                merged[8*b +: 8] = w_data_q[8*b +: 8];
            end
        end
        merged = merged & field_mask(aw_sel[1:0]);
    end

    always_comb begin
        aw_full_d = aw_full_q;
        aw_word_d = aw_word_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_word_d = s_axi_awaddr[AXI_ADDR_WIDTH-1:3];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end
        if (b_hs) begin
            bvalid_d = 1'b0;
        end

        // Both halves present: apply the write and raise the response in one edge.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (aw_in_range) begin
                regs_d[aw_sel] = merged;
                bresp_d        = RESP_OKAY;
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (r_hs) begin
            rvalid_d = 1'b0;
        end
        // Sampling regs_q (not regs_d) makes a same-edge commit invisible to this read.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (ar_in_range) begin
                rdata_d = regs_q[ar_sel];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            aw_full_q <= 1'b0;
            aw_word_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            regs_q    <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_word_q <= aw_word_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign int_cfg_regs = regs_q;

endmodule
